// File: rtl/udp_wave_unpack_pkg.sv
// udp_wave_unpack_pkg
// Shared constants for the waveform unpacker: FSM state encoding (one-hot,
// 4 bits), application header length, source tag codes, default magic word,
// and small saturating/validation helpers.
package udp_wave_unpack_pkg;

   localparam logic [3:0] ST_IDLE = 4'b0001;
   localparam logic [3:0] ST_HDR  = 4'b0010;
   localparam logic [3:0] ST_DATA = 4'b0100;
   localparam logic [3:0] ST_DROP = 4'b1000;

   localparam int unsigned HDR_LEN = 4;

   localparam logic [1:0]  SRC_A         = 2'b01;
   localparam logic [1:0]  SRC_B         = 2'b10;
   localparam logic [15:0] MAGIC_DEFAULT = 16'h5AA5;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {9'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   function automatic logic src_valid(input logic [1:0] s);
      return (s == SRC_A) || (s == SRC_B);
   endfunction

endpackage

// File: rtl/udp_wave_unpack_if.sv
// udp_wave_unpack_if
// Per-byte payload stream from the UDP receive stage.
//   rec_en        byte valid, one byte per cycle
//   rec_data      payload byte
//   rec_pkt_done  high with the last byte's rec_en
//   rec_byte_num  payload length in bytes, valid with rec_pkt_done
//   wave_source   01 = A, 10 = B, valid while rec_en is high
// master: receive stage (driver), slave: unpacker (consumer).
interface udp_wave_unpack_if;
   logic        rec_en;
   logic [7:0]  rec_data;
   logic        rec_pkt_done;
   logic [15:0] rec_byte_num;
   logic [1:0]  wave_source;

   modport master (output rec_en, rec_data, rec_pkt_done, rec_byte_num, wave_source);
   modport slave  (input  rec_en, rec_data, rec_pkt_done, rec_byte_num, wave_source);
endinterface

// File: rtl/udp_wave_unpack_ping_pong_ctrl.sv
// ping_pong_ctrl
// Bank selector for one source's ping-pong sample RAM.
//   clk, rst_n  clock, async active-low reset
//   commit      one-cycle strobe: the write bank becomes the readable bank
//   rd_bank     committed (readable) bank
//   wr_bank     bank currently being filled (~rd_bank)
module ping_pong_ctrl (
   input  logic clk,
   input  logic rst_n,
   input  logic commit,
   output logic rd_bank,
   output logic wr_bank
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_bank <= 1'b0;
      else if (commit)
         rd_bank <= ~rd_bank;
   end

   assign wr_bank = ~rd_bank;

endmodule

// File: rtl/udp_wave_unpack.sv
// udp_wave_unpack
// Validates the application header of each UDP payload and packs big-endian
// 16-bit samples into a per-source ping-pong sample RAM. Good packets are
// committed as a frame (bank flip + frame_valid pulse); bad packets bump
// err_cnt and leave the committed bank alone.
// Optional macro SEQ_CHECK_EN adds per-source sequence tracking and lost_cnt.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rec                   payload stream (udp_wave_unpack_if.slave)
//   buf_wr_en/addr/data   sample RAM write, addr = {src, bank, index}
//   frame_valid           one-cycle commit pulse with frame_src, frame_len
//   rd_bank_a, rd_bank_b  committed bank per source
//   err_cnt               discarded packets, saturating
//   lost_cnt              (SEQ_CHECK_EN) missing sequence numbers, saturating
//
// state | meaning
// IDLE  | waiting for first byte of a packet
// HDR   | checking magic bytes, latching seq
// DATA  | packing sample bytes into the write bank
// DROP  | packet rejected, ignoring bytes until rec_pkt_done
module udp_wave_unpack
   import udp_wave_unpack_pkg::*;
#(
   parameter logic [15:0] MAGIC       = MAGIC_DEFAULT,
   parameter int          ADDR_W      = 10,
   parameter int          MAX_SAMPLES = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   udp_wave_unpack_if.slave    rec,
   output logic                buf_wr_en,
   output logic [ADDR_W+1:0]   buf_wr_addr,
   output logic [15:0]         buf_wr_data,
   output logic                frame_valid,
   output logic                frame_src,
   output logic [ADDR_W:0]     frame_len,
   output logic                rd_bank_a,
   output logic                rd_bank_b,
   output logic [15:0]         err_cnt
`ifdef SEQ_CHECK_EN
   ,
   output logic [15:0]         lost_cnt
`endif
);

   localparam logic [ADDR_W:0] MAX_S = (ADDR_W+1)'(MAX_SAMPLES);

   logic [3:0]      state, st_nxt;
   logic [15:0]     byte_cnt, cnt_nxt;
   logic [ADDR_W:0] samp_cnt, samp_nxt;
   logic            hdr_done, hdr_nxt;
   logic [1:0]      src_q, src_cur;
   logic [7:0]      hi_q;
   logic            wr_req, pkt_good, src_is_b;
   logic            commit_a, commit_b, wr_bank_a, wr_bank_b;

   // Source is taken straight from the bus on the first byte so a packet's
   // first cycle (and a 1-byte packet) sees the right tag.
   assign src_cur  = (state == ST_IDLE) ? rec.wave_source : src_q;
   assign src_is_b = (src_cur == SRC_B);

   always_comb begin
      st_nxt   = state;
      hdr_nxt  = hdr_done;
      samp_nxt = samp_cnt;
      wr_req   = 1'b0;
      if (rec.rec_en) begin
         case (state)
            ST_IDLE: begin
               if (!src_valid(rec.wave_source) || rec.rec_data != MAGIC[15:8])
                  st_nxt = ST_DROP;
               else
                  st_nxt = ST_HDR;
            end
            ST_HDR: begin
               if (byte_cnt == 16'd1 && rec.rec_data != MAGIC[7:0]) begin
                  st_nxt = ST_DROP;
               end else if (byte_cnt == 16'(HDR_LEN - 1)) begin
                  st_nxt  = ST_DATA;
                  hdr_nxt = 1'b1;
               end
            end
            ST_DATA: begin
               // Data starts at an even offset, so odd byte_cnt is a low byte.
               if (byte_cnt[0]) begin
                  if (samp_cnt == MAX_S) begin
                     st_nxt = ST_DROP;
                  end else begin
                     wr_req   = 1'b1;
                     samp_nxt = samp_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
      cnt_nxt  = byte_cnt + {15'd0, rec.rec_en};
      // Judged on the post-byte view so a DROP caused by the final byte counts.
      pkt_good = rec.rec_pkt_done && (st_nxt != ST_DROP) && hdr_nxt &&
                 (cnt_nxt == rec.rec_byte_num) && !rec.rec_byte_num[0] &&
                 (rec.rec_byte_num >= 16'd6) && src_valid(src_cur);
   end

   assign commit_a = pkt_good && (src_cur == SRC_A);
   assign commit_b = pkt_good && (src_cur == SRC_B);

   ping_pong_ctrl u_pp_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .commit  (commit_a),
      .rd_bank (rd_bank_a),
      .wr_bank (wr_bank_a)
   );

   ping_pong_ctrl u_pp_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .commit  (commit_b),
      .rd_bank (rd_bank_b),
      .wr_bank (wr_bank_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         byte_cnt    <= '0;
         samp_cnt    <= '0;
         hdr_done    <= 1'b0;
         src_q       <= '0;
         hi_q        <= '0;
         buf_wr_en   <= 1'b0;
         buf_wr_addr <= '0;
         buf_wr_data <= '0;
         frame_valid <= 1'b0;
         frame_src   <= 1'b0;
         frame_len   <= '0;
         err_cnt     <= '0;
      end else begin
         buf_wr_en   <= wr_req;
         frame_valid <= pkt_good;
         if (wr_req) begin
            buf_wr_addr <= {src_is_b, (src_is_b ? wr_bank_b : wr_bank_a), samp_cnt[ADDR_W-1:0]};
            buf_wr_data <= {hi_q, rec.rec_data};
         end
         if (pkt_good) begin
            frame_src <= src_is_b;
            frame_len <= samp_nxt;
         end
         if (rec.rec_en && state == ST_IDLE)
            src_q <= rec.wave_source;
         if (rec.rec_en && state == ST_DATA && !byte_cnt[0])
            hi_q <= rec.rec_data;
         if (rec.rec_pkt_done) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            samp_cnt <= '0;
            hdr_done <= 1'b0;
            if (!pkt_good)
               err_cnt <= sat_add16(err_cnt, 8'd1);
         end else begin
            state    <= st_nxt;
            byte_cnt <= cnt_nxt;
            samp_cnt <= samp_nxt;
            hdr_done <= hdr_nxt;
         end
      end
   end

`ifdef SEQ_CHECK_EN
   logic [7:0] seq_q, exp_a, exp_b;
   logic       seeded_a, seeded_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q    <= '0;
         exp_a    <= '0;
         exp_b    <= '0;
         seeded_a <= 1'b0;
         seeded_b <= 1'b0;
         lost_cnt <= '0;
      end else begin
         if (rec.rec_en && state == ST_HDR && byte_cnt == 16'd2)
            seq_q <= rec.rec_data;
         // Gap is modulo 256, so a wrapped sequence counts forward.
         if (commit_a) begin
            if (seeded_a)
               lost_cnt <= sat_add16(lost_cnt, seq_q - exp_a);
            exp_a    <= seq_q + 8'd1;
            seeded_a <= 1'b1;
         end
         if (commit_b) begin
            if (seeded_b)
               lost_cnt <= sat_add16(lost_cnt, seq_q - exp_b);
            exp_b    <= seq_q + 8'd1;
            seeded_b <= 1'b1;
         end
      end
   end
`endif

endmodule
